mcu_ram_ctrl: RTL and testbench

MCU_RAM_CTRL -- requirements
Module: mcu_ram_ctrl

---
 rtl/mcu_ram_pkg.sv | 14 +
 rtl/mcu_ram_arb.sv | 45 ++++
 rtl/mcu_ram_ctrl.sv | 85 ++++++++
 tb/tb_mcu_ram_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_ram_pkg.sv
// Shared defaults and owner-tag encoding for the MCU_RAM controller.
// Optional round-robin arbitration: define MCU_RAM_CTRL_RR_EN.
package mcu_ram_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mcu_ram_arb.sv
// Single-cycle grant logic for the fetch and data ports.
// MCU_RAM_CTRL_RR_EN selects round-robin, else data port has priority.
module mcu_ram_arb (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  output logic i_gnt,
  output logic d_gnt
);

`ifdef MCU_RAM_CTRL_RR_EN
  logic last_d_q;
  logic last_d_d;
  logic d_win;

  // Pointer only moves when both ports compete.
  always_comb begin
    d_win    = d_req;
    last_d_d = last_d_q;
    if (i_req && d_req) begin
      d_win    = ~last_d_q;
      last_d_d = ~last_d_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end

  assign d_gnt = ~reset & d_win;
  assign i_gnt = ~reset & i_req & ~d_win;
`else
  logic unused_clk;
  assign unused_clk = clk;

  assign d_gnt = ~reset & d_req;
  assign i_gnt = ~reset & i_req & ~d_req;
`endif

endmodule

// File: rtl/mcu_ram_ctrl.sv
// Two-port (fetch/data) front end for a single-port MCU_RAM.
// Build option: MCU_RAM_CTRL_RR_EN enables round-robin arbitration.
module mcu_ram_ctrl
  import mcu_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  owner_e            owner_q;
  owner_e            owner_d;
  logic [DATA_W-1:0] i_hold_q;
  logic [DATA_W-1:0] i_hold_d;
  logic [DATA_W-1:0] d_hold_q;
  logic [DATA_W-1:0] d_hold_d;

  mcu_ram_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .i_req (i_req),
    .d_req (d_req),
    .i_gnt (i_gnt),
    .d_gnt (d_gnt)
  );

  assign ram_ce    = i_gnt | d_gnt;
  assign ram_wre   = d_gnt & d_we;
  assign ram_ad    = d_gnt ? d_addr : i_addr;
  assign ram_din   = d_wdata;
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;

  always_comb begin
    owner_d  = OWN_NONE;
    i_hold_d = i_hold_q;
    d_hold_d = d_hold_q;
    unique case (1'b1)
      i_gnt:          owner_d = OWN_I;
      d_gnt && !d_we: owner_d = OWN_D;
      default:        owner_d = OWN_NONE;
    endcase
    if (owner_q == OWN_I) i_hold_d = ram_dout;
    if (owner_q == OWN_D) d_hold_d = ram_dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      owner_q  <= owner_d;
      i_hold_q <= i_hold_d;
      d_hold_q <= d_hold_d;
    end
  end

  assign i_rvalid = (owner_q == OWN_I);
  assign d_rvalid = (owner_q == OWN_D);
  assign i_rdata  = i_rvalid ? ram_dout : i_hold_q;
  assign d_rdata  = d_rvalid ? ram_dout : d_hold_q;

endmodule

// File: tb/tb_mcu_ram_ctrl.sv
// Directed and random checks of mcu_ram_ctrl against a transaction model.
// Works with or without MCU_RAM_CTRL_RR_EN defined.
module tb_mcu_ram_ctrl;

  localparam int AW = 11;
  localparam int DW = 16;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          ram_ce;
  logic          ram_oce;
  logic          ram_wre;
  logic          ram_reset;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  int total = 0;
  int bad = 0;

  mcu_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
    .ram_reset(ram_reset), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    case (a)
      11'd0:   return 16'hC008;
      11'd1:   return 16'h9109;
      11'd2:   return 16'h8009;
      11'd3:   return 16'h1908;
      default: return {a[10:0], 5'b0} ^ 16'h3C5A;
    endcase
  endfunction

  // Synchronous single-port RAM with registered output.
  logic [DW-1:0] ram_mem [NW];
  bit            ram_wr  [NW];
  always @(posedge clk) begin
    if (ram_reset) begin
      ram_dout <= '0;
    end else if (ram_ce) begin
      if (ram_wre) begin
        ram_mem[ram_ad] <= ram_din;
        ram_wr[ram_ad]  <= 1'b1;
      end else begin
        ram_dout <= ram_wr[ram_ad] ? ram_mem[ram_ad]
                                   : init_val(ram_ad);
      end
    end
  end

  // Transaction-level reference state.
  logic [DW-1:0] ref_mem [NW];
  bit            exp_irv;
  bit            exp_drv;
  logic [DW-1:0] exp_ird;
  logic [DW-1:0] exp_drd;
`ifdef MCU_RAM_CTRL_RR_EN
  bit            last_d;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_irv = 1'b0;
    exp_drv = 1'b0;
    exp_ird = '0;
    exp_drd = '0;
`ifdef MCU_RAM_CTRL_RR_EN
    last_d = 1'b0;
`endif
  endtask

  // Drive one cycle from posedge+1, check mid-cycle, advance.
  task automatic cyc(input bit ir, input logic [AW-1:0] ia,
                     input bit dr, input bit dwe,
                     input logic [AW-1:0] da,
                     input logic [DW-1:0] dwd);
    bit eg_i;
    bit eg_d;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    eg_d = dr;
`ifdef MCU_RAM_CTRL_RR_EN
    if (ir && dr) begin
      eg_d   = !last_d;
      last_d = eg_d;
    end
`endif
    eg_i = ir && !eg_d;
    chk("i_gnt", i_gnt, eg_i);
    chk("d_gnt", d_gnt, eg_d);
    chk("ram_ce", ram_ce, eg_i | eg_d);
    chk("ram_wre", ram_wre, eg_d & dwe);
    if (eg_i || eg_d) chk("ram_ad", ram_ad, eg_d ? da : ia);
    if (eg_d && dwe) chk("ram_din", ram_din, dwd);
    chk("i_rvalid", i_rvalid, exp_irv);
    chk("d_rvalid", d_rvalid, exp_drv);
    chk("i_rdata", i_rdata, exp_ird);
    chk("d_rdata", d_rdata, exp_drd);
    exp_irv = eg_i;
    if (eg_i) exp_ird = ref_mem[ia];
    exp_drv = eg_d && !dwe;
    if (exp_drv) exp_drd = ref_mem[da];
    if (eg_d && dwe) ref_mem[da] = dwd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  logic [DW-1:0] img [4];

  initial begin
    for (int a = 0; a < NW; a++) ref_mem[a] = init_val(AW'(a));
    img[0] = 16'hC008; img[1] = 16'h9109;
    img[2] = 16'h8009; img[3] = 16'h1908;
    model_reset();

    // Requests during reset must not be granted.
    i_req = 1'b1; d_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_ce", ram_ce, 0);
    chk("rst_wre", ram_wre, 0);
    chk("rst_i_rv", i_rvalid, 0);
    chk("rst_d_rv", d_rvalid, 0);
    chk("rst_i_rd", i_rdata, 0);
    chk("rst_d_rd", d_rdata, 0);
    chk("rst_ramrst", ram_reset, 1);
    chk("oce", ram_oce, 1);
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("ramrst_off", ram_reset, 0);

    // Fetch of word 0 from the default image.
    cyc(1'b1, 11'h000, 1'b0, 1'b0, '0, '0);
    chk("f0_rv", i_rvalid, 1);
    chk("f0_rd", i_rdata, 16'hC008);
    idle();

    // Write then read-back of the same address.
    cyc(1'b0, '0, 1'b1, 1'b1, 11'h010, 16'h5A5A);
    cyc(1'b0, '0, 1'b1, 1'b0, 11'h010, '0);
    chk("wr_rd_rv", d_rvalid, 1);
    chk("wr_rd_rd", d_rdata, 16'h5A5A);
    chk("wr_rd_irv", i_rvalid, 0);
    idle();

    // Contention held for four cycles.
    repeat (4) cyc(1'b1, 11'h002, 1'b1, 1'b0, 11'h003, '0);
    idle();

    // Back-to-back fetch stream.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, AW'(k), 1'b0, 1'b0, '0, '0);
      chk("strm_rv", i_rvalid, 1);
      chk("strm_rd", i_rdata, img[k]);
    end
    idle();

    // Fetch data held while data port writes.
    cyc(1'b1, 11'h001, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      chk("hold_rd", i_rdata, 16'h9109);
      cyc(1'b0, '0, 1'b1, 1'b1, AW'(32 + k), DW'(16'h1000 + k));
    end
    chk("hold_rd", i_rdata, 16'h9109);
    chk("hold_rv", i_rvalid, 0);

    // Reset while a data read is in flight.
    d_req = 1'b1; d_we = 1'b0; d_addr = 11'h010;
    @(negedge clk);
    chk("fl_gnt", d_gnt, 1);
    #2 reset = 1'b1;
    #1 chk("fl_gnt_rst", d_gnt, 0);
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    chk("fl_rv", d_rvalid, 0);
    chk("fl_rd", d_rdata, 16'h0000);
    idle();
    chk("fl_rv2", d_rvalid, 0);
    chk("fl_rd2", d_rdata, 16'h0000);

    // Random traffic, mostly in a small window to force reuse.
    for (int n = 0; n < 500; n++) begin
      logic [AW-1:0] ia;
      logic [AW-1:0] da;
      ia = ($urandom_range(0, 7) == 0) ? AW'($urandom)
                                       : AW'($urandom_range(0, 15));
      da = ($urandom_range(0, 7) == 0) ? AW'($urandom)
                                       : AW'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 1)), ia,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          da, DW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
